// File: rtl/turn_sequencer_pkg.sv
// Shared definitions for the turn sequencer: FSM encoding, player codes, picture width
// and small helpers used by the top level.
package turn_sequencer_pkg;

   localparam int unsigned PIC_W = 4;

   typedef enum logic [3:0] {
      StIdle,
      StWaitPick,
      StReveal,
      StJudge,
      StAdvance,
      StSettle,
      StCheck,
      StNextTurn,
      StGameOver
   } state_e;

   localparam logic [1:0] P_NONE = 2'd0;
   localparam logic [1:0] P1     = 2'd1;
   localparam logic [1:0] P2     = 2'd2;
   localparam logic [1:0] P3     = 2'd3;

   // Turn decoder: wraps back to P1 after the last seated player.
   function automatic logic [1:0] next_player(input logic [1:0] cur, input logic [1:0] last);
      logic [1:0] nxt;
      if (cur == last) begin
         nxt = P1;
      end else begin
         case (cur)
            P_NONE:  nxt = P1;
            P1:      nxt = P2;
            P2:      nxt = P3;
            P3:      nxt = P1;
            default: nxt = P1;
         endcase
      end
      return nxt;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned max_cycles);
      return (max_cycles > 1) ? $clog2(max_cycles) : 1;
   endfunction

endpackage

// File: rtl/turn_sequencer_cycle_timer.sv
// Loadable down-counter. Holds at zero; tc is high while running with the count at zero,
// so a load of N-1 followed by N run cycles flags the last of those cycles.
module cycle_timer #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             run,
   input  logic [Width-1:0] load_val,
   output logic             tc
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (run && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc = run && (cnt_q == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Turn/advance sequencer for the board game: takes a card pick, reveals it, judges it
// against the tile ahead of the current player and either advances or passes the turn.
module turn_sequencer
   import turn_sequencer_pkg::*;
#(
   parameter int unsigned NUM_PLAYERS    = 3,
   parameter int unsigned NUM_CARDS      = 12,
   parameter int unsigned REVEAL_CYCLES  = 50_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pick_valid,
   input  logic [3:0]       pick_idx,
   input  logic [PIC_W-1:0] card_pic,
   input  logic [PIC_W-1:0] tile_pic,
   input  logic             win_in,
   output logic [1:0]       T,
   output logic             B,
   output logic             reveal,
   output logic [3:0]       reveal_idx,
   output logic             miss,
   output logic             game_over
);

   localparam int unsigned MaxCycles =
      (REVEAL_CYCLES > TIMEOUT_CYCLES) ? REVEAL_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = cnt_width(MaxCycles);
   localparam logic [CntW-1:0] RevLoad = CntW'(REVEAL_CYCLES - 1);
   localparam logic [CntW-1:0] TmoLoad = CntW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] LastPlayer = 2'(NUM_PLAYERS);

   state_e state_q;
   logic   match_q;
   logic   rev_tc;
   logic   tmo_tc;
   logic   pick_ok;

   assign pick_ok = pick_valid && (32'(pick_idx) < NUM_CARDS);

   // Each timer sits preloaded while its state is inactive, so it starts fresh on entry.
   cycle_timer #(
      .Width (CntW)
   ) u_reveal_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q != StReveal),
      .run      (state_q == StReveal),
      .load_val (RevLoad),
      .tc       (rev_tc)
   );

   cycle_timer #(
      .Width (CntW)
   ) u_timeout_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q != StWaitPick),
      .run      (state_q == StWaitPick),
      .load_val (TmoLoad),
      .tc       (tmo_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         T          <= P_NONE;
         B          <= 1'b0;
         reveal     <= 1'b0;
         reveal_idx <= '0;
         miss       <= 1'b0;
         game_over  <= 1'b0;
         match_q    <= 1'b0;
      end else begin
         B    <= 1'b0;
         miss <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  T       <= P1;
                  state_q <= StWaitPick;
               end
            end
            StWaitPick: begin
               // A valid pick takes priority over a timeout in the same cycle.
               if (pick_ok) begin
                  reveal_idx <= pick_idx;
                  match_q    <= (card_pic == tile_pic);
                  reveal     <= 1'b1;
                  state_q    <= StReveal;
               end else if (tmo_tc) begin
                  miss    <= 1'b1;
                  state_q <= StNextTurn;
               end
            end
            StReveal: begin
               if (rev_tc) begin
                  reveal  <= 1'b0;
                  state_q <= StJudge;
               end
            end
            StJudge: begin
               if (match_q) begin
                  B       <= 1'b1;
                  state_q <= StAdvance;
               end else begin
                  miss    <= 1'b1;
                  state_q <= StNextTurn;
               end
            end
            StAdvance: begin
               state_q <= StSettle;
            end
            StSettle: begin
               state_q <= StCheck;
            end
            StCheck: begin
               if (win_in) begin
                  game_over <= 1'b1;
                  state_q   <= StGameOver;
               end else begin
                  state_q <= StWaitPick;
               end
            end
            StNextTurn: begin
               T       <= next_player(T, LastPlayer);
               state_q <= StWaitPick;
            end
            StGameOver: begin
               if (start) begin
                  game_over <= 1'b0;
                  T         <= P1;
                  state_q   <= StWaitPick;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized bench for turn_sequencer: the driver pushes expected output events with their
// cycle stamps into a scoreboard; a negedge monitor turns DUT output changes into events.
module tb_turn_sequencer;
   import turn_sequencer_pkg::*;

   localparam int unsigned REV = 4;
   localparam int unsigned TMO = 20;
   localparam int unsigned NP  = 3;
   localparam int unsigned NC  = 12;

   localparam int EvT    = 0;
   localparam int EvRon  = 1;
   localparam int EvRoff = 2;
   localparam int EvB    = 3;
   localparam int EvMiss = 4;
   localparam int EvWin  = 5;
   localparam int EvGoff = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             pick_valid = 1'b0;
   logic [3:0]       pick_idx = '0;
   logic [PIC_W-1:0] card_pic = '0;
   logic [PIC_W-1:0] tile_pic = '0;
   logic             win_in = 1'b0;
   logic [1:0]       T;
   logic             B;
   logic             reveal;
   logic [3:0]       reveal_idx;
   logic             miss;
   logic             game_over;

   turn_sequencer #(
      .NUM_PLAYERS    (NP),
      .NUM_CARDS      (NC),
      .REVEAL_CYCLES  (REV),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx),
      .card_pic   (card_pic),
      .tile_pic   (tile_pic),
      .win_in     (win_in),
      .T          (T),
      .B          (B),
      .reveal     (reveal),
      .reveal_idx (reveal_idx),
      .miss       (miss),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int val;
      int cyc;
   } ev_t;

   ev_t sbq[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  cyc = 0;
   bit  mon_en = 1'b0;
   int  cur_t = 0;
   bit  over = 1'b0;

   logic [1:0] p_t = '0;
   logic       p_rev = 1'b0;
   logic       p_go = 1'b0;

   function automatic string kname(input int k);
      case (k)
         EvT:     return "T_change";
         EvRon:   return "reveal_on";
         EvRoff:  return "reveal_off";
         EvB:     return "B_pulse";
         EvMiss:  return "miss_pulse";
         EvWin:   return "game_over_rise";
         default: return "game_over_fall";
      endcase
   endfunction

   task automatic expect_ev(input int k, input int v, input int c);
      ev_t e;
      e.kind = k;
      e.val  = v;
      e.cyc  = c;
      sbq.push_back(e);
   endtask

   task automatic observe(input int k, input int v);
      ev_t e;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: actual %s val=%0d cyc=%0d, required no event",
                  kname(k), v, cyc);
      end else begin
         e = sbq.pop_front();
         if (e.kind != k || e.val != v || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: actual %s val=%0d cyc=%0d, required %s val=%0d cyc=%0d",
                     kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual %0d, required %0d", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: every DUT output change becomes an event checked against the scoreboard.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (T != p_t)               observe(EvT, int'(T));
            if (reveal && !p_rev)       observe(EvRon, int'(reveal_idx));
            if (!reveal && p_rev)       observe(EvRoff, int'(reveal_idx));
            if (B)                      observe(EvB, int'(T));
            if (miss)                   observe(EvMiss, int'(T));
            if (game_over && !p_go)     observe(EvWin, int'(T));
            if (!game_over && p_go)     observe(EvGoff, int'(T));
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
               e = sbq.pop_front();
               n_cmp++;
               n_err++;
               $display("FAIL missing_event: actual none by cyc=%0d, required %s val=%0d cyc=%0d",
                        cyc, kname(e.kind), e.val, e.cyc);
            end
         end
         p_t   = T;
         p_rev = reveal;
         p_go  = game_over;
      end
   end

   task automatic drive(input bit pv, input int idx, input int cp, input int tp,
                        input bit w, input bit st);
      pick_valid = pv;
      pick_idx   = 4'(idx);
      card_pic   = PIC_W'(cp);
      tile_pic   = PIC_W'(tp);
      win_in     = w;
      start      = st;
      @(posedge clk);
      #1;
      pick_valid = 1'b0;
      start      = 1'b0;
      win_in     = 1'b0;
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int next_of(input int p);
      return (p % int'(NP)) + 1;
   endfunction

   // Noise cycle in WAIT_PICK: only out-of-range picks and stray win flags.
   task automatic wait_noise();
      drive(rb(), int'(NC) + $urandom_range(0, 15 - NC), $urandom_range(0, 15),
            $urandom_range(0, 15), rb(), 1'b0);
   endtask

   task automatic do_start();
      int c;
      c = cyc;
      if (cur_t != 1) expect_ev(EvT, 1, c + 1);
      if (over) expect_ev(EvGoff, 1, c + 1);
      drive(1'b0, 0, 0, 0, rb(), 1'b1);
      cur_t = 1;
      over  = 1'b0;
   endtask

   task automatic pick_turn(input int d, input int idx, input int cp, input int tp,
                            input bit win);
      int c;
      int nxt;
      for (int i = 0; i < d; i++) wait_noise();
      c = cyc;
      expect_ev(EvRon, idx, c + 1);
      expect_ev(EvRoff, idx, c + 1 + int'(REV));
      drive(1'b1, idx, cp, tp, rb(), 1'b0);
      // Extra picks and starts while revealing must be ignored.
      for (int i = 0; i < int'(REV); i++) begin
         drive(rb(), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
               rb(), rb());
      end
      if (cp == tp) begin
         expect_ev(EvB, cur_t, c + int'(REV) + 2);
         drive(1'b0, 0, 0, 0, rb(), 1'b0);
         drive(1'b0, 0, 0, 0, rb(), 1'b0);
         drive(1'b0, 0, 0, 0, rb(), 1'b0);
         if (win) begin
            expect_ev(EvWin, cur_t, c + int'(REV) + 5);
            over = 1'b1;
         end
         drive(1'b0, 0, 0, 0, win, 1'b0);
      end else begin
         nxt = next_of(cur_t);
         expect_ev(EvMiss, cur_t, c + int'(REV) + 2);
         if (nxt != cur_t) expect_ev(EvT, nxt, c + int'(REV) + 3);
         drive(1'b0, 0, 0, 0, rb(), 1'b0);
         drive(1'b0, 0, 0, 0, rb(), 1'b0);
         cur_t = nxt;
      end
   endtask

   task automatic timeout_turn();
      int w;
      int nxt;
      w   = cyc;
      nxt = next_of(cur_t);
      expect_ev(EvMiss, cur_t, w + int'(TMO));
      if (nxt != cur_t) expect_ev(EvT, nxt, w + int'(TMO) + 1);
      for (int i = 0; i < int'(TMO); i++) wait_noise();
      drive(1'b0, 0, 0, 0, rb(), 1'b0);
      cur_t = nxt;
   endtask

   task automatic over_noise(input int n);
      int p;
      for (int i = 0; i < n; i++) begin
         p = $urandom_range(0, 15);
         drive(rb(), $urandom_range(0, NC - 1), p, p, rb(), 1'b0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_T"}, int'(T), 0);
      chk({tag, "_B"}, int'(B), 0);
      chk({tag, "_reveal"}, int'(reveal), 0);
      chk({tag, "_reveal_idx"}, int'(reveal_idx), 0);
      chk({tag, "_miss"}, int'(miss), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
   endtask

   task automatic reset_mid_reveal();
      int c;
      c = cyc;
      expect_ev(EvRon, 7, c + 1);
      drive(1'b1, 7, 1, 1, 1'b0, 1'b0);
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("reveal_before_abort", int'(reveal), 1);
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      check_all_zero("abort_async");
      @(posedge clk);
      #1;
      check_all_zero("abort_edge");
      rst = 1'b0;
      sbq.delete();
      cur_t  = 0;
      over   = 1'b0;
      mon_en = 1'b1;
      // Back in IDLE: picks and win flags do nothing until start.
      drive(1'b1, 3, 5, 5, 1'b1, 1'b0);
      drive(1'b1, 4, 6, 6, 1'b1, 1'b0);
      do_start();
   endtask

   initial begin
      int cp;
      int tp;
      rst    = 1'b1;
      mon_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst    = 1'b0;
      mon_en = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      do_start();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("T_after_start", int'(T), 1);
      chk("game_over_after_start", int'(game_over), 0);

      pick_turn(2, 5, 3, 3, 1'b0);
      chk("T_after_match", int'(T), 1);

      for (int i = 0; i < 3; i++) pick_turn($urandom_range(0, 5), $urandom_range(0, NC - 1),
                                            2, 7, 1'b0);
      chk("T_after_three_misses", int'(T), 1);

      pick_turn(0, 1, 2, 7, 1'b0);
      drive(1'b1, 13, 0, 0, 1'b0, 1'b0);
      drive(1'b1, 13, 4, 4, 1'b0, 1'b0);
      chk("reveal_after_bad_idx", int'(reveal), 0);
      // Two WAIT_PICK cycles already spent above; finish the timeout window.
      begin
         int w;
         w = cyc - 2;
         expect_ev(EvMiss, 2, w + int'(TMO));
         expect_ev(EvT, 3, w + int'(TMO) + 1);
         for (int i = 2; i < int'(TMO); i++) wait_noise();
         drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
         cur_t = 3;
      end
      chk("T_after_timeout", int'(T), 3);

      // Pick on the timeout cycle itself, with a win.
      pick_turn(int'(TMO) - 1, 4, 9, 9, 1'b1);
      chk("game_over_on_win", int'(game_over), 1);
      chk("T_holds_winner", int'(T), 3);
      over_noise(10);
      do_start();
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      chk("game_over_cleared", int'(game_over), 0);

      reset_mid_reveal();

      for (int k = 0; k < 60; k++) begin
         if (over) begin
            over_noise($urandom_range(1, 6));
            do_start();
         end else if ($urandom_range(0, 9) == 0) begin
            timeout_turn();
         end else begin
            cp = $urandom_range(0, 15);
            tp = rb() ? cp : $urandom_range(0, 15);
            pick_turn($urandom_range(0, TMO - 1), $urandom_range(0, NC - 1), cp, tp,
                      (cp == tp) && ($urandom_range(0, 3) == 0));
         end
      end

      repeat (3) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
      while (sbq.size() > 0) begin
         ev_t e;
         e = sbq.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL leftover_event: actual none, required %s val=%0d cyc=%0d",
                  kname(e.kind), e.val, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
